// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle for the sequential divider.
//   start      - request strobe, sampled only while the divider is idle/done
//   dividend   - unsigned numerator, captured on an accepted start
//   divisor    - unsigned denominator, captured on an accepted start
//   busy       - division in progress
//   done       - one-cycle completion strobe
//   quotient   - result, held until the next accepted start completes
//   remainder  - result, held until the next accepted start completes
//   divByZero  - divisor was zero for the reported result
// master = requester side, slave = divider side.
interface seq_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             divByZero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, divByZero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, divByZero
   );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-high; returns to IDLE and clears outputs
//   bus    - seq_divider_if.slave (start/operands in, busy/done/results out)
// A start with divisor 0 reports quotient=all ones, remainder=dividend and
// divByZero the very next cycle without iterating. Otherwise WIDTH iterations
// run in RUN and results appear with a one-cycle done strobe.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   seq_divider_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] q;        // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] r;        // partial remainder, always < d between steps
   logic [WIDTH-1:0] d;        // captured divisor
   logic [CW-1:0]    count;
   logic             busy_r, done_r, dbz_r;
   logic [WIDTH-1:0] quot_r, rem_r;

   // The shifted remainder R' is WIDTH+1 bits, but since R < D its top bit is
   // simply r[WIDTH-1]. When that bit is set, R' >= 2^WIDTH > D and the
   // subtraction must succeed; its low WIDTH bits are then exactly the
   // WIDTH-bit chain result. So one WIDTH-bit A + ~B + 1 chain suffices, and
   // (r_top | cout) is the carry-out of the full WIDTH+1 bit subtraction.
   logic             r_top;
   logic [WIDTH-1:0] rs_lo;
   logic [WIDTH:0]   chain;
   logic             sub_ok;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   always_comb begin
      r_top  = r[WIDTH-1];
      rs_lo  = {r[WIDTH-2:0], q[WIDTH-1]};
      chain  = {1'b0, rs_lo} + {1'b0, ~d} + {{WIDTH{1'b0}}, 1'b1};
      sub_ok = r_top | chain[WIDTH];
      r_next = sub_ok ? chain[WIDTH-1:0] : rs_lo;
      q_next = {q[WIDTH-2:0], sub_ok};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         q      <= '0;
         r      <= '0;
         d      <= '0;
         count  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         quot_r <= '0;
         rem_r  <= '0;
      end else begin
         case (state)
            RUN: begin
               // start is ignored here; operands live in q/d
               q     <= q_next;
               r     <= r_next;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  quot_r <= q_next;
                  rem_r  <= r_next;
               end
            end
            default: begin  // IDLE and DONE accept identically
               if (bus.start) begin
                  if (bus.divisor == '0) begin
                     state  <= DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     dbz_r  <= 1'b1;
                     quot_r <= '1;
                     rem_r  <= bus.dividend;
                  end else begin
                     state  <= RUN;
                     busy_r <= 1'b1;
                     done_r <= 1'b0;
                     dbz_r  <= 1'b0;
                     q      <= bus.dividend;
                     r      <= '0;
                     d      <= bus.divisor;
                     count  <= '0;
                  end
               end else begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.divByZero = dbz_r;
   assign bus.quotient  = quot_r;
   assign bus.remainder = rem_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed check of seq_divider (WIDTH=8)
// against plain integer division.
module tb_seq_divider;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Walk negedges until done; edges = clock edges after the accept edge.
   task automatic wait_done(output int edges, input logic exp_busy);
      edges = 0;
      while (bus.done !== 1'b1 && edges < 64) begin
         if (exp_busy) chk("busy_run", bus.busy, 1);
         @(negedge clk);
         edges++;
      end
      if (edges >= 64) chk("done_timeout", 0, 1);
   endtask

   task automatic check_result(input logic [W-1:0] n, input logic [W-1:0] d);
      logic [31:0] eq, er, qo, ro;
      if (d == 0) begin
         eq = 32'hFF;
         er = 32'(n);
      end else begin
         eq = 32'(n) / 32'(d);
         er = 32'(n) % 32'(d);
      end
      qo = 32'(bus.quotient);
      ro = 32'(bus.remainder);
      chk("quotient", qo, eq);
      chk("remainder", ro, er);
      chk("div_by_zero", bus.divByZero, (d == 0) ? 1 : 0);
      if (d != 0) begin
         chk("inv_qd_plus_r", qo * 32'(d) + ro, 32'(n));
         chk("inv_r_lt_d", (ro < 32'(d)) ? 1 : 0, 1);
      end
   endtask

   task automatic do_div(input logic [W-1:0] n, input logic [W-1:0] d);
      int e;
      logic [W-1:0] qh;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = n; bus.divisor = d;
      @(negedge clk);
      // operands must already be captured
      bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
      wait_done(e, d != 0);
      chk("latency", e, (d == 0) ? 0 : W);
      chk("busy_at_done", bus.busy, 0);
      check_result(n, d);
      qh = bus.quotient;
      @(negedge clk);
      chk("done_one_cycle", bus.done, 0);
      chk("quotient_held", bus.quotient, qh);
   endtask

   initial begin
      int e, ndone, c1, c2;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_quotient", bus.quotient, 0);
      chk("rst_remainder", bus.remainder, 0);
      chk("rst_dbz", bus.divByZero, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // directed corners
      do_div(8'd100, 8'd7);
      do_div(8'd255, 8'd1);
      do_div(8'd5,   8'd9);
      do_div(8'd255, 8'd255);
      do_div(8'd200, 8'd0);
      do_div(8'd9,   8'd3);

      // start pulsed during RUN is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd6;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done === 1'b1) ndone++;
         @(negedge clk);
      end
      chk("ignored_start_done_count", ndone, 1);
      chk("ignored_start_quotient", bus.quotient, 14);
      chk("ignored_start_remainder", bus.remainder, 2);

      // async reset mid-RUN
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrun_rst_busy", bus.busy, 0);
      chk("midrun_rst_done", bus.done, 0);
      chk("midrun_rst_quotient", bus.quotient, 0);
      chk("midrun_rst_remainder", bus.remainder, 0);
      chk("midrun_rst_dbz", bus.divByZero, 0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
         @(negedge clk);
      end
      chk("midrun_rst_no_activity", ndone, 0);
      chk("midrun_rst_quotient_after", bus.quotient, 0);
      do_div(8'd17, 8'd4);

      // start held across DONE: back-to-back
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 8'd60; bus.divisor = 8'd8;
      @(negedge clk);
      bus.dividend = 8'd81; bus.divisor = 8'd9;
      wait_done(e, 1'b1);
      c1 = cyc;
      chk("b2b_first_latency", e, W);
      check_result(8'd60, 8'd8);
      @(negedge clk);
      chk("b2b_busy_after_done", bus.busy, 1);
      chk("b2b_done_one_cycle", bus.done, 0);
      wait_done(e, 1'b1);
      c2 = cyc;
      bus.start = 1'b0;
      chk("b2b_spacing", c2 - c1, 9);
      check_result(8'd81, 8'd9);
      @(negedge clk);
      chk("b2b_idle_busy", bus.busy, 0);
      chk("b2b_idle_done", bus.done, 0);

      // random sweep, occasional zero divisor
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] n, d;
         n = W'($urandom);
         d = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
         do_div(n, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
